// File: rtl/mips_run_ctrl.sv
// mips_run_ctrl: sequences a small MIPS core through program load,
// a processor-reset hold, a bounded run and a frozen done state.
//
// Load handshake: a beat transfers on a rising clk edge when load_valid and
// load_ready are both high. load_ready is high only in LOAD and does not
// depend on load_valid. load_data/load_last are sampled with the beat.
// The memory write strobe is the transfer condition itself.
module mips_run_ctrl #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 8,
  parameter int CNT_W      = 16,
  parameter int RST_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              skip_load,
  input  logic [CNT_W-1:0]  run_cycles,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  input  logic              halt_in,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_CPURST = 3'd2,
    S_RUN    = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W:0]   words_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  limit_q;
  logic [RC_W-1:0]   rcnt_q;
  logic              done_q;
  logic              timeout_q;

  logic              accept;
  logic              ptr_full;
  logic [CNT_W-1:0]  cnt_d;

  // Beat acceptance, memory-full detect and saturating run-cycle increment
  always_comb begin
    accept   = load_valid && (state_q == S_LOAD);
    ptr_full = &ptr_q;
    cnt_d    = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
  end

  // Output decode: everything except RUN keeps the processor in reset
  always_comb begin
    load_ready   = (state_q == S_LOAD);
    busy         = (state_q == S_LOAD) || (state_q == S_CPURST) || (state_q == S_RUN);
    cpu_rst      = (state_q != S_RUN);
    mem_we       = accept;
    mem_addr     = ptr_q;
    mem_wdata    = load_data;
    done         = done_q;
    timeout      = timeout_q;
    cycle_count  = cnt_q;
    words_loaded = words_q;
  end

  // Run-control FSM with its counters and registered status flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      words_q   <= '0;
      cnt_q     <= '0;
      limit_q   <= '0;
      rcnt_q    <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        // DONE relaunches exactly like IDLE; start is only seen here
        S_IDLE, S_DONE: begin
          if (start) begin
            ptr_q     <= '0;
            words_q   <= '0;
            cnt_q     <= '0;
            limit_q   <= run_cycles;
            rcnt_q    <= '0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            state_q   <= skip_load ? S_CPURST : S_LOAD;
          end
        end
        // The pointer parks at the last address instead of wrapping
        S_LOAD: begin
          if (accept) begin
            words_q <= words_q + 1'b1;
            if (!ptr_full) begin
              ptr_q <= ptr_q + 1'b1;
            end
            if (load_last || ptr_full) begin
              state_q <= S_CPURST;
            end
          end
        end
        S_CPURST: begin
          if (rcnt_q == RC_W'(RST_CYCLES - 1)) begin
            state_q <= S_RUN;
          end else begin
            rcnt_q <= rcnt_q + 1'b1;
          end
        end
        // Halt is checked first so it wins over a simultaneous limit hit
        S_RUN: begin
          cnt_q <= cnt_d;
          if (halt_in) begin
            state_q   <= S_DONE;
            done_q    <= 1'b1;
            timeout_q <= 1'b0;
          end else if ((limit_q != '0) && (cnt_d == limit_q)) begin
            state_q   <= S_DONE;
            done_q    <= 1'b1;
            timeout_q <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Bench for mips_run_ctrl: randomized load/run episodes against an
// arithmetic model of the expected write list, run length and flags,
// plus a small-memory instance for the full/saturation corners.
module tb_mips_run_ctrl;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int CW = 16;
  localparam int RC = 3;
  localparam int S_AW = 2;
  localparam int S_CW = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // main instance signals
  logic          start = 1'b0, skip_load = 1'b0, load_valid = 1'b0, load_last = 1'b0, halt_in = 1'b0;
  logic [CW-1:0] run_cycles = '0;
  logic [DW-1:0] load_data = '0;
  logic          load_ready, mem_we, cpu_rst, busy, done, timeout;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [CW-1:0] cycle_count;
  logic [AW:0]   words_loaded;

  // small instance signals
  logic            s_start = 1'b0, s_valid = 1'b0, s_last = 1'b0, s_halt = 1'b0;
  logic [S_CW-1:0] s_run_cycles = '0;
  logic [DW-1:0]   s_data = '0;
  logic            s_load_ready, s_mem_we, s_cpu_rst, s_busy, s_done, s_timeout;
  logic [S_AW-1:0] s_mem_addr;
  logic [DW-1:0]   s_mem_wdata;
  logic [S_CW-1:0] s_cycle_count;
  logic [S_AW:0]   s_words_loaded;

  int n_checks = 0;
  int n_errors = 0;
  logic [AW+DW-1:0] exp_q[$];

  mips_run_ctrl #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW), .RST_CYCLES(RC)) u_dut (
    .clk(clk), .rst(rst), .start(start), .skip_load(skip_load), .run_cycles(run_cycles),
    .load_valid(load_valid), .load_data(load_data), .load_last(load_last), .load_ready(load_ready),
    .halt_in(halt_in), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_rst(cpu_rst), .busy(busy), .done(done), .timeout(timeout),
    .cycle_count(cycle_count), .words_loaded(words_loaded)
  );

  mips_run_ctrl #(.DATA_W(DW), .ADDR_W(S_AW), .CNT_W(S_CW), .RST_CYCLES(1)) u_dut_small (
    .clk(clk), .rst(rst), .start(s_start), .skip_load(1'b0), .run_cycles(s_run_cycles),
    .load_valid(s_valid), .load_data(s_data), .load_last(s_last), .load_ready(s_load_ready),
    .halt_in(s_halt), .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
    .cpu_rst(s_cpu_rst), .busy(s_busy), .done(s_done), .timeout(s_timeout),
    .cycle_count(s_cycle_count), .words_loaded(s_words_loaded)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // scoreboard: every write strobe must match the next expected (addr,data)
  always @(negedge clk) begin
    logic [AW+DW-1:0] e;
    if (rst && mem_we) begin
      if (exp_q.size() == 0) begin
        check("mem_we_unexpected", mem_we, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check("mem_addr", mem_addr, e[AW+DW-1:DW]);
        check("mem_wdata", mem_wdata, e[DW-1:0]);
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cpu_rst"}, cpu_rst, 1'b1);
    check({tag, "_load_ready"}, load_ready, 1'b0);
    check({tag, "_mem_we"}, mem_we, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_timeout"}, timeout, 1'b0);
    check({tag, "_cycle_count"}, cycle_count, 0);
    check({tag, "_words"}, words_loaded, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
  endtask

  // called at posedge+1; asserts reset mid-cycle, checks, releases
  task automatic pulse_reset(input string tag);
    #2 rst = 1'b0;
    load_valid = 1'b1;
    #1 check_reset_outputs(tag);
    @(negedge clk);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 check({tag, "_no_relaunch"}, busy, 1'b0);
    load_valid = 1'b0;
  endtask

  task automatic launch(input bit skip, input int limit);
    @(posedge clk); #1;
    start = 1'b1; skip_load = skip; run_cycles = CW'(limit);
    @(posedge clk); #1;
    start = 1'b0;
    skip_load = 1'($urandom_range(0, 1));
    run_cycles = CW'($urandom);
  endtask

  // one full episode; expectations come from plain arithmetic on the inputs
  task automatic run_case(input bit skip, input int limit, input int nwords,
                          input int last_at, input int halt_at);
    logic [DW-1:0] data[16];
    int acc, exp_run, i, cyc, rst_cyc, run_n;
    bit win, fin;
    logic [CW-1:0] cc_hold;
    for (int k = 0; k < 16; k++) data[k] = $urandom;
    acc = skip ? 0 : last_at;
    for (int k = 0; k < acc; k++) exp_q.push_back({AW'(k), data[k]});
    win = (halt_at != 0) && ((limit == 0) || (halt_at <= limit));
    exp_run = win ? halt_at : limit;

    launch(skip, limit);
    check("start_clr_done", done, 1'b0);
    check("start_clr_timeout", timeout, 1'b0);
    check("start_clr_count", cycle_count, 0);
    check("start_clr_words", words_loaded, 0);
    check("start_busy", busy, 1'b1);

    i = 0; cyc = 0; rst_cyc = 0; run_n = 0; fin = 1'b0;
    while (!fin && cyc < 400) begin
      if (busy && cpu_rst && !load_ready) rst_cyc++;
      if (!cpu_rst) begin
        run_n++;
        halt_in = (run_n == halt_at);
      end else begin
        halt_in = 1'b0;
      end
      if (i < nwords && $urandom_range(0, 3) != 0) begin
        load_valid = 1'b1; load_data = data[i]; load_last = (i + 1 == last_at);
      end else begin
        load_valid = 1'b0; load_last = 1'b0; load_data = $urandom;
      end
      @(negedge clk);
      if (load_valid && load_ready) i++;
      @(posedge clk); #1;
      cyc++;
      fin = done;
    end
    load_valid = 1'b0; load_last = 1'b0; halt_in = 1'b0;

    check("run_finished", fin, 1'b1);
    check("cpurst_len", rst_cyc, RC);
    check("run_len", run_n, exp_run);
    check("timeout", timeout, !win);
    check("cycle_count", cycle_count, exp_run);
    check("words_loaded", words_loaded, acc);
    check("done_busy", busy, 1'b0);
    check("done_cpu_rst", cpu_rst, 1'b1);
    check("writes_seen", exp_q.size(), 0);
    exp_q.delete();

    // DONE must hold its results regardless of halt/load activity
    cc_hold = cycle_count;
    halt_in = 1'b1; load_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("hold_done", done, 1'b1);
    check("hold_count", cycle_count, cc_hold);
    check("hold_words", words_loaded, acc);
    check("hold_timeout", timeout, !win);
    halt_in = 1'b0; load_valid = 1'b0;
  endtask

  initial begin
    int run_n, cyc, pulse_at, s_acc, s_run;
    int nw, la, lim, ha;
    logic [DW-1:0] sd[6];
    logic [AW+DW-1:0] tmp;

    // reset
    #2 rst = 1'b0;
    #1 check_reset_outputs("por");
    check("por_small_cpu_rst", s_cpu_rst, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // small memory: 6 beats without load_last, only 4 fit
    for (int j = 0; j < 6; j++) sd[j] = $urandom;
    @(posedge clk); #1;
    s_start = 1'b1; s_run_cycles = '0;
    @(posedge clk); #1;
    s_start = 1'b0;
    s_acc = 0;
    for (int j = 0; j < 6; j++) begin
      s_valid = 1'b1; s_data = sd[j]; s_last = 1'b0;
      @(negedge clk);
      if (s_mem_we) begin
        check("s_addr", s_mem_addr, s_acc);
        check("s_wdata", s_mem_wdata, sd[j]);
        s_acc++;
      end
      if (j == 4) check("s_ready_after_full", s_load_ready, 1'b0);
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    check("s_accepted", s_acc, (6 < (1 << S_AW)) ? 6 : (1 << S_AW));
    check("s_words", s_words_loaded, 1 << S_AW);
    // unlimited run, halt at cycle 20 -> counter saturates at 15
    s_run = 0; cyc = 0;
    while (!s_done && cyc < 100) begin
      if (!s_cpu_rst) begin s_run++; s_halt = (s_run == 20); end else s_halt = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    s_halt = 1'b0;
    check("s_run_len", s_run, 20);
    check("s_cycle_sat", s_cycle_count, (1 << S_CW) - 1);
    check("s_timeout", s_timeout, 1'b0);
    check("s_done", s_done, 1'b1);

    // directed episodes
    run_case(1'b0, 20, 5, 5, 7);
    run_case(1'b1, 18, 3, 3, 0);
    run_case(1'b0, 3, 2, 2, 3);
    run_case(1'b0, 1, 1, 1, 0);

    // start during CPURST and RUN must be ignored
    pulse_at = $urandom_range(1, 9);
    launch(1'b1, 10);
    run_n = 0; cyc = 0;
    while (!done && cyc < 100) begin
      if (!cpu_rst) run_n++;
      start = (cyc == 0) || (!cpu_rst && run_n == pulse_at);
      skip_load = 1'b0; run_cycles = CW'(2);
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    check("busy_start_run_len", run_n, 10);
    check("busy_start_count", cycle_count, 10);
    check("busy_start_timeout", timeout, 1'b1);

    // relaunch from DONE, then randomized episodes
    for (int n = 0; n < 14; n++) begin
      nw = $urandom_range(1, 8);
      la = $urandom_range(1, nw);
      lim = $urandom_range(0, 25);
      ha = (lim == 0) ? $urandom_range(1, 25) : $urandom_range(0, 30);
      run_case(1'($urandom_range(0, 1)), lim, nw, la, ha);
    end

    // reset during RUN cycle 4
    launch(1'b1, 0);
    run_n = 0; cyc = 0;
    while (run_n < 4 && cyc < 50) begin
      if (!cpu_rst) run_n++;
      if (run_n < 4) begin @(posedge clk); #1; cyc++; end
    end
    check("rst_run_reached", run_n, 4);
    pulse_reset("rst_run");

    // reset during LOAD after two accepted beats
    launch(1'b0, 0);
    for (int k = 0; k < 2; k++) begin
      tmp = {AW'(k), DW'($urandom)};
      exp_q.push_back(tmp);
      load_valid = 1'b1; load_data = tmp[DW-1:0]; load_last = 1'b0;
      @(posedge clk); #1;
    end
    load_valid = 1'b0;
    check("rst_load_words_before", words_loaded, 2);
    pulse_reset("rst_load");
    check("rst_load_writes_seen", exp_q.size(), 0);
    exp_q.delete();

    // a fresh start works after reset
    run_case(1'b0, 12, 4, 3, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
